// File: rtl/pudding_chain_pkg.sv
// Shared types for the PUDDING daisychain master: command opcodes and FSM states.
`timescale 1ns/1ps
package pudding_chain_pkg;

  localparam int unsigned CHAIN_LEN_DEFAULT = 128;

  typedef enum logic [1:0] {
    OP_SHIFT  = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_COMMIT = 2'b11
  } chain_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SHIFT,
    S_GAP,
    S_COMMIT,
    S_RESP
  } master_state_e;

endpackage

// File: rtl/pudding_chain_master.sv
// PUDDING daisychain initiator: turns word commands into datum/shift/transfer/dir
// pin sequences (MSB first) and captures the serial readback from the chain tap.
`timescale 1ns/1ps
module pudding_chain_master
  import pudding_chain_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = CHAIN_LEN_DEFAULT,
  parameter int unsigned GAP       = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [CHAIN_LEN-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [CHAIN_LEN-1:0] rsp_data,
  output logic                 chain_datum,
  output logic                 chain_shift,
  output logic                 chain_transfer,
  output logic                 chain_dir,
  output logic                 chain_stateen,
  input  logic                 chain_tap
);

  localparam int unsigned   CW         = $clog2(CHAIN_LEN + 1);
  localparam int unsigned   GW         = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CW-1:0] LAST_BIT   = CW'(CHAIN_LEN - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'((GAP > 0) ? GAP - 1 : 0);

  master_state_e        state_q, state_d;
  master_state_e        ret_q, ret_d;
  master_state_e        pulse_next;
  chain_op_e            op_q, op_d;
  logic [CHAIN_LEN-1:0] tx_q, tx_d;
  logic [CHAIN_LEN-1:0] rx_q, rx_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [GW-1:0]        gap_q, gap_d;
  logic                 pulse_slot;

  logic                 datum_q, shift_q, transfer_q, dir_q, stateen_q;
  logic                 rsp_valid_q;
  logic [CHAIN_LEN-1:0] rsp_data_q;

  assign cmd_ready      = (state_q == S_IDLE) && rst_n;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign chain_datum    = datum_q;
  assign chain_shift    = shift_q;
  assign chain_transfer = transfer_q;
  assign chain_dir      = dir_q;
  assign chain_stateen  = stateen_q;

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    op_d       = op_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    bit_d      = bit_q;
    gap_d      = gap_q;
    pulse_next = S_RESP;
    pulse_slot = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = chain_op_e'(cmd_op);
          tx_d  = cmd_data;
          rx_d  = '0;
          bit_d = '0;
          unique case (chain_op_e'(cmd_op))
            OP_READ:   state_d = S_LOAD;
            OP_COMMIT: state_d = S_COMMIT;
            default:   state_d = S_SHIFT;
          endcase
        end
      end
      S_LOAD: begin
        pulse_slot = 1'b1;
        pulse_next = S_SHIFT;
      end
      S_SHIFT: begin
        pulse_slot = 1'b1;
        tx_d       = tx_q << 1;
        rx_d       = {rx_q[CHAIN_LEN-2:0], chain_tap};
        bit_d      = bit_q + CW'(1);
        if (bit_q != LAST_BIT) pulse_next = S_SHIFT;
        else if (op_q == OP_WRITE) pulse_next = S_COMMIT;
        else pulse_next = S_RESP;
      end
      S_COMMIT: begin
        pulse_slot = 1'b1;
        pulse_next = S_RESP;
      end
      S_GAP: begin
        if (gap_q == '0) state_d = ret_q;
        else gap_d = gap_q - GW'(1);
      end
      S_RESP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every pulse is followed by GAP idle cycles; the target after them is parked in ret_q.
    if (pulse_slot) begin
      if (GAP == 0) begin
        state_d = pulse_next;
      end else begin
        state_d = S_GAP;
        ret_d   = pulse_next;
        gap_d   = GAP_RELOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ret_q       <= S_IDLE;
      op_q        <= OP_SHIFT;
      tx_q        <= '0;
      rx_q        <= '0;
      bit_q       <= '0;
      gap_q       <= '0;
      datum_q     <= 1'b0;
      shift_q     <= 1'b0;
      transfer_q  <= 1'b0;
      dir_q       <= 1'b0;
      stateen_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      op_q        <= op_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      bit_q       <= bit_d;
      gap_q       <= gap_d;
      // Pin registers follow state_d so each strobe is aligned with the state it belongs to.
      datum_q     <= (state_d == S_SHIFT) && tx_d[CHAIN_LEN-1];
      shift_q     <= (state_d == S_SHIFT);
      transfer_q  <= (state_d == S_LOAD) || (state_d == S_COMMIT);
      dir_q       <= (state_d == S_COMMIT);
      stateen_q   <= 1'b1;
      rsp_valid_q <= (state_d == S_RESP);
      rsp_data_q  <= (state_d == S_RESP) ? rx_d : '0;
    end
  end

endmodule

// File: tb/tb_pudding_chain_master.sv
// Bench for pudding_chain_master: two masters (GAP=0 and GAP=1), each driving a
// behavioural PUDDING chain/state model; a per-cycle pin-sequence model checks both.
`timescale 1ns/1ps
module tb_pudding_chain_master;
  import pudding_chain_pkg::*;

  localparam int unsigned N = 128;
  localparam logic [N-1:0] PAT = 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rstn [2];
  logic         cv   [2];
  logic [1:0]   cop  [2];
  logic [N-1:0] cd   [2];
  logic         rr   [2];
  logic         crdy [2];
  logic         rv   [2];
  logic [N-1:0] rd   [2];
  logic         dat  [2];
  logic         sh   [2];
  logic         tr   [2];
  logic         dr   [2];
  logic         se   [2];

  logic [N-1:0] chn [2] = '{'0, '0};
  logic [N-1:0] sto [2] = '{'0, '0};

  int total = 0;
  int bad   = 0;

  pudding_chain_master #(.CHAIN_LEN(N), .GAP(0)) u_gap0 (
    .clk(clk), .rst_n(rstn[0]), .cmd_valid(cv[0]), .cmd_ready(crdy[0]), .cmd_op(cop[0]),
    .cmd_data(cd[0]), .rsp_valid(rv[0]), .rsp_ready(rr[0]), .rsp_data(rd[0]),
    .chain_datum(dat[0]), .chain_shift(sh[0]), .chain_transfer(tr[0]), .chain_dir(dr[0]),
    .chain_stateen(se[0]), .chain_tap(chn[0][N-1])
  );

  pudding_chain_master #(.CHAIN_LEN(N), .GAP(1)) u_gap1 (
    .clk(clk), .rst_n(rstn[1]), .cmd_valid(cv[1]), .cmd_ready(crdy[1]), .cmd_op(cop[1]),
    .cmd_data(cd[1]), .rsp_valid(rv[1]), .rsp_ready(rr[1]), .rsp_data(rd[1]),
    .chain_datum(dat[1]), .chain_shift(sh[1]), .chain_transfer(tr[1]), .chain_dir(dr[1]),
    .chain_stateen(se[1]), .chain_tap(chn[1][N-1])
  );

  // Target chip: MSB-first daisychain, transfer+dir=1 commits, transfer+dir=0 loads.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (sh[i]) chn[i] <= {chn[i][N-2:0], dat[i]};
      else if (tr[i] && dr[i]) sto[i] <= chn[i];
      else if (tr[i]) chn[i] <= sto[i];
    end
  end

  task automatic check_bit(input string name, input int w, input logic a, input logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[g%0d] t=%0t: got %b want %b", name, w, $time, a, e);
    end
  endtask

  task automatic check_vec(input string name, input int w, input logic [N-1:0] a, input logic [N-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[g%0d] t=%0t: got %h want %h", name, w, $time, a, e);
    end
  endtask

  task automatic check_int(input string name, input int w, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s[g%0d] t=%0t: got %0d want %0d", name, w, $time, a, e);
    end
  endtask

  // Per-instance reference model state.
  bit           chk_en [2] = '{1'b0, 1'b0};
  bit           act    [2] = '{1'b0, 1'b0};
  int           t      [2] = '{0, 0};
  int           gapv   [2] = '{0, 1};
  chain_op_e    mop    [2];
  logic [N-1:0] mdat   [2];
  logic [N-1:0] mexp   [2];

  function automatic int pulses(input chain_op_e op);
    case (op)
      OP_SHIFT:  return N;
      OP_COMMIT: return 1;
      default:   return N + 1;
    endcase
  endfunction

  task automatic step(input int w);
    int  s, p_cnt, idx, p, k;
    bit  on, e_sh, e_tr, e_dr, e_rv;
    if (!chk_en[w]) return;
    s = 1 + gapv[w];
    if (act[w]) begin
      t[w]++;
      p_cnt = pulses(mop[w]);
      idx   = t[w] - 1;
      p     = idx / s;
      on    = (idx % s == 0) && (p < p_cnt);
      e_sh = 1'b0; e_tr = 1'b0; e_dr = 1'b0; k = 0;
      if (on) begin
        case (mop[w])
          OP_SHIFT: begin e_sh = 1'b1; k = p; end
          OP_WRITE: if (p < N) begin e_sh = 1'b1; k = p; end else begin e_tr = 1'b1; e_dr = 1'b1; end
          OP_READ:  if (p == 0) e_tr = 1'b1; else begin e_sh = 1'b1; k = p - 1; end
          default:  begin e_tr = 1'b1; e_dr = 1'b1; end
        endcase
      end
      e_rv = (t[w] >= 1 + p_cnt * s);
      check_bit("shift", w, sh[w], e_sh);
      check_bit("transfer", w, tr[w], e_tr);
      check_bit("dir", w, dr[w], e_dr);
      if (e_sh) check_bit("datum", w, dat[w], mdat[w][N-1-k]);
      check_bit("cmd_ready_busy", w, crdy[w], 1'b0);
      check_bit("stateen", w, se[w], 1'b1);
      check_bit("rsp_valid", w, rv[w], e_rv);
      if (e_rv) begin
        check_vec("rsp_data", w, rd[w], mexp[w]);
        if (rr[w]) act[w] = 1'b0;
      end
    end else begin
      check_bit("idle_shift", w, sh[w], 1'b0);
      check_bit("idle_transfer", w, tr[w], 1'b0);
      check_bit("idle_dir", w, dr[w], 1'b0);
      check_bit("idle_rsp_valid", w, rv[w], 1'b0);
      check_bit("idle_cmd_ready", w, crdy[w], 1'b1);
      check_bit("idle_stateen", w, se[w], 1'b1);
      if (cv[w] && crdy[w]) begin
        act[w]  = 1'b1;
        t[w]    = 0;
        mop[w]  = chain_op_e'(cop[w]);
        mdat[w] = cd[w];
        case (chain_op_e'(cop[w]))
          OP_SHIFT, OP_WRITE: mexp[w] = chn[w];
          OP_READ:            mexp[w] = sto[w];
          default:            mexp[w] = '0;
        endcase
      end
    end
  endtask

  always @(negedge clk) begin
    step(0);
    step(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic timeout_fail(input string name, input int w);
    total++;
    bad++;
    $display("FAIL %s[g%0d] t=%0t: got timeout want event", name, w, $time);
  endtask

  // Issues one command and returns with rsp_valid visible; lat is the cycle index it rose in.
  task automatic issue(input int w, input chain_op_e op, input logic [N-1:0] data, output int lat);
    int n;
    cv[w] = 1'b1; cop[w] = op; cd[w] = data;
    n = 0;
    while (!crdy[w] && n < 50) begin tick(); n++; end
    if (!crdy[w]) timeout_fail("accept", w);
    tick();
    cv[w] = 1'b0;
    lat = 1;
    while (!rv[w] && lat < 600) begin tick(); lat++; end
    if (!rv[w]) timeout_fail("rsp_wait", w);
  endtask

  initial begin
    #50000;
    bad++;
    $display("FAIL watchdog: got no finish want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int lat;
    logic [N-1:0] held;
    for (int i = 0; i < 2; i++) begin
      rstn[i] = 1'b0; cv[i] = 1'b0; cop[i] = 2'b00; cd[i] = '0; rr[i] = 1'b1;
    end
    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check_bit("rst_shift", i, sh[i], 1'b0);
      check_bit("rst_transfer", i, tr[i], 1'b0);
      check_bit("rst_dir", i, dr[i], 1'b0);
      check_bit("rst_datum", i, dat[i], 1'b0);
      check_bit("rst_stateen", i, se[i], 1'b0);
      check_bit("rst_rsp_valid", i, rv[i], 1'b0);
      check_vec("rst_rsp_data", i, rd[i], '0);
      check_bit("rst_cmd_ready", i, crdy[i], 1'b0);
      rstn[i] = 1'b1;
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      check_bit("post_rst_stateen", i, se[i], 1'b1);
      check_bit("post_rst_cmd_ready", i, crdy[i], 1'b1);
      chk_en[i] = 1'b1;
    end

    // GAP=0: back-to-back shifts, exchange semantics.
    issue(0, OP_SHIFT, '1, lat);
    check_int("shift_ones_latency", 0, lat, 129);
    check_vec("shift_ones_rsp", 0, rd[0], '0);
    tick();
    check_vec("shift_ones_chain", 0, chn[0], '1);
    issue(0, OP_SHIFT, '0, lat);
    check_int("shift_zeros_latency", 0, lat, 129);
    check_vec("shift_zeros_rsp", 0, rd[0], '1);
    tick();
    check_vec("shift_zeros_chain", 0, chn[0], '0);
    check_vec("shift_no_commit", 0, sto[0], '0);

    // GAP=1: WRITE then READ back.
    issue(1, OP_WRITE, PAT, lat);
    check_int("write_latency", 1, lat, 259);
    check_vec("write_rsp", 1, rd[1], '0);
    tick();
    check_vec("write_state", 1, sto[1], PAT);
    check_vec("write_chain", 1, chn[1], PAT);
    issue(1, OP_READ, '0, lat);
    check_int("read_latency", 1, lat, 259);
    check_vec("read_rsp", 1, rd[1], PAT);
    tick();
    check_vec("read_chain", 1, chn[1], '0);
    check_vec("read_state", 1, sto[1], PAT);

    // Reset during the 40th shift pulse (cycle 79) of a WRITE.
    cv[1] = 1'b1; cop[1] = OP_WRITE; cd[1] = ~PAT;
    tick();
    cv[1] = 1'b0;
    repeat (78) tick();
    check_bit("shift40_pulse", 1, sh[1], 1'b1);
    chk_en[1] = 1'b0; act[1] = 1'b0;
    rstn[1] = 1'b0;
    tick();
    check_bit("abort_shift", 1, sh[1], 1'b0);
    check_bit("abort_transfer", 1, tr[1], 1'b0);
    check_bit("abort_dir", 1, dr[1], 1'b0);
    check_bit("abort_datum", 1, dat[1], 1'b0);
    check_bit("abort_stateen", 1, se[1], 1'b0);
    check_bit("abort_rsp_valid", 1, rv[1], 1'b0);
    check_bit("abort_cmd_ready", 1, crdy[1], 1'b0);
    repeat (2) begin
      tick();
      check_bit("abort_hold_rsp_valid", 1, rv[1], 1'b0);
    end
    rstn[1] = 1'b1;
    tick();
    check_bit("abort_release_cmd_ready", 1, crdy[1], 1'b1);
    check_bit("abort_release_stateen", 1, se[1], 1'b1);
    check_bit("abort_release_rsp_valid", 1, rv[1], 1'b0);
    tick();
    check_vec("abort_no_commit", 1, sto[1], PAT);
    chk_en[1] = 1'b1;

    // COMMIT with rsp_ready held low; a second command waits for the handshake.
    rr[1] = 1'b0;
    issue(1, OP_COMMIT, ~PAT, lat);
    check_int("commit_latency", 1, lat, 3);
    held = rd[1];
    check_vec("commit_rsp", 1, held, '0);
    cv[1] = 1'b1; cop[1] = OP_COMMIT; cd[1] = PAT;
    repeat (10) begin
      tick();
      check_bit("hold_rsp_valid", 1, rv[1], 1'b1);
      check_vec("hold_rsp_data", 1, rd[1], held);
      check_bit("hold_cmd_ready", 1, crdy[1], 1'b0);
    end
    rr[1] = 1'b1;
    tick();
    check_bit("after_hs_rsp_valid", 1, rv[1], 1'b0);
    check_bit("after_hs_cmd_ready", 1, crdy[1], 1'b1);
    tick();
    cv[1] = 1'b0;
    check_bit("second_commit_transfer", 1, tr[1], 1'b1);
    check_bit("second_commit_dir", 1, dr[1], 1'b1);
    check_bit("second_commit_cmd_ready", 1, crdy[1], 1'b0);
    repeat (2) tick();
    check_bit("second_commit_rsp_valid", 1, rv[1], 1'b1);
    tick();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pudding_chain_master.md
Name: pudding_chain_master

Overview:
- Clocked initiator for the PUDDING daisychain protocol.
- Turns word-level commands (shift/exchange, write, read, commit) into datum/shift/transfer/dir/stateen pin sequences for heichips25_pudding.
- Captures the serial readback on the chain MSB tap.
- Sits on the host/FPGA side of the chip pins, or in-loop with heichips25_pudding for system simulation.

Parameters:
- CHAIN_LEN, 128, daisychain/state length in bits.
- GAP, 1, idle cycles after every shift or transfer pulse; 0 means back-to-back pulses.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE with rst_n high
- cmd_op  in  2  00 SHIFT, 01 WRITE, 10 READ, 11 COMMIT
- cmd_data  in  CHAIN_LEN  payload to shift in
- rsp_valid  out  1  response available, held until rsp_ready
- rsp_ready  in  1  response accept
- rsp_data  out  CHAIN_LEN  bits shifted out of the chain
- chain_datum  out  1  drives ui_in[0]
- chain_shift  out  1  drives ui_in[1]
- chain_transfer  out  1  drives ui_in[2]
- chain_dir  out  1  drives ui_in[3]
- chain_stateen  out  1  drives ui_in[4]
- chain_tap  in  1  from uo_out[7], i.e. daisychain[CHAIN_LEN-1]

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is synchronous, active-low.
- All chain_* outputs and rsp_* are registered.
- Reset values:
  - all chain_* = 0, rsp_valid = 0, rsp_data = 0, state = IDLE.
  - chain_stateen = 1 from the first cycle after rst_n is sampled high.
- Reset mid-operation: abort at the next edge. All outputs return to reset values, no response is produced, and no commit occurs.
- Handshake: command accepted when cmd_valid && cmd_ready, call this cycle 0. cmd_data is latched into tx_sr and rx_sr is cleared.
- Pulse slot: each pulse occupies one cycle with its strobe high, followed by GAP cycles with all strobes low. Slot length is 1+GAP.
- Transfer/dir rules:
  - chain_transfer and chain_shift are never high together.
  - chain_dir is 0 except during a COMMIT pulse, when chain_dir = 1 together with chain_transfer.
- Bit order: MSB first.
  - In shift slot k (k = 0..CHAIN_LEN-1), chain_datum = tx_sr[CHAIN_LEN-1].
  - At the edge ending the shift cycle: rx_sr <= {rx_sr, chain_tap} (tap sampled pre-shift) and tx_sr <= tx_sr << 1.
  - After CHAIN_LEN shifts, the chain equals cmd_data and rx equals the old chain.
- Operations and FSM:
  - SHIFT: CHAIN_LEN shift slots (pure exchange); state register untouched.
  - WRITE: CHAIN_LEN shift slots, then one COMMIT slot (transfer, dir=1).
  - READ: one LOAD slot (transfer, dir=0), then CHAIN_LEN shift slots. rsp_data = state contents; the chain ends holding cmd_data.
  - COMMIT: one commit slot only. rsp_data = 0.
  - State sequence: IDLE -> LOAD? -> SHIFT/GAP loop (bit counter 0..CHAIN_LEN-1, width $clog2(CHAIN_LEN+1)) -> COMMIT? -> RESP -> IDLE.
  - GAP is realised with a down-counter; GAP=0 skips the GAP state entirely.
- Latency: with P pulses, the first pulse is in cycle 1 and rsp_valid rises in cycle 1+P*(1+GAP).
  - SHIFT: P = CHAIN_LEN
  - WRITE, READ: P = CHAIN_LEN+1
  - COMMIT: P = 1
- Response: in RESP, rsp_valid=1 and rsp_data is held stable until rsp_ready. Return to IDLE on the edge where rsp_valid && rsp_ready. cmd_ready = 0 throughout. Commands are never queued.
- cmd_valid with cmd_ready low is ignored; cmd_data is only sampled at acceptance.

Decomposition:
- Package pudding_chain_pkg:
  - chain_op_e {OP_SHIFT, OP_WRITE, OP_READ, OP_COMMIT}
  - master_state_e {S_IDLE, S_LOAD, S_SHIFT, S_GAP, S_COMMIT, S_RESP}
  - CHAIN_LEN_DEFAULT = 128
- Single module, no sub-module. Shift registers and counters are inline; the GAP counter is too small to justify its own block.

Test Plan:
- Setup for all tests: master wired to heichips25_pudding, GAP=1.
- WRITE 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210 after reset -> chain_shift pulses in cycles 1,3,...,255; commit in cycle 257; rsp_valid in cycle 259. Expect rsp_data=0, uo_out=8'h01, uio_out=8'h01.
- READ with cmd_data=0 after the WRITE above -> LOAD pulse in cycle 1 with chain_dir=0. Expect rsp_data=pattern, uio_out still 8'h01, uo_out=8'h00 at the end.
- SHIFT all-ones after reset, then SHIFT all-zeros -> first rsp_data=0, second rsp_data=all ones. uio_out stays 8'h00 (no commit).
- GAP=0, SHIFT -> chain_shift high for 128 consecutive cycles (1..128); rsp_valid in cycle 129. Data is correct against the chain model.
- Reset asserted in the cycle of the 40th shift pulse of a WRITE -> all chain_* are 0 at the next edge and no rsp_valid. After release, cmd_ready=1 and uio_out=8'h00 (never committed).
- Hold rsp_ready low for 10 cycles after a COMMIT -> rsp_valid and rsp_data stay stable and cmd_ready stays 0. A cmd_valid asserted meanwhile is not accepted until the cycle after the response handshake.
